// File: rtl/data_ctrl_pkg.sv
// rtl/data_ctrl_pkg.sv - shared types and defaults for the cache data-array controller
package data_ctrl_pkg;

   localparam int DEF_SET_W  = 10;
   localparam int DEF_WAY_W  = 2;
   localparam int DEF_BEAT_W = 128;
   localparam int NUM_QTR    = 4;
   localparam int RD_LAT     = 2;

   typedef enum logic {
      IDLE,
      FILL
   } state_t;

endpackage

// File: rtl/data_ctrl_rd_pipe.sv
// rtl/data_ctrl_rd_pipe.sv - two-stage lookup valid/set tracker for the bank read pipeline
module data_ctrl_rd_pipe #(
   parameter int SET_W = 10
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [SET_W-1:0] in_set,
   output logic             s1_valid,
   output logic [SET_W-1:0] s1_set,
   output logic             rsp_valid,
   output logic [SET_W-1:0] rsp_set
);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid  <= 1'b0;
         s1_set    <= '0;
         rsp_valid <= 1'b0;
         rsp_set   <= '0;
      end else begin
         s1_valid  <= in_valid;
         s1_set    <= in_set;
         rsp_valid <= s1_valid;
         rsp_set   <= s1_set;
      end
   end

endmodule

// File: rtl/data_array_ctrl.sv
// rtl/data_array_ctrl.sv - sequences lookups, line fills and quarter stores into four data banks
// Optional DATA_CTRL_PERF_EN adds lookup-stall and write-hold cycle counters.
module data_array_ctrl
   import data_ctrl_pkg::*;
#(
   parameter int SET_W  = DEF_SET_W,
   parameter int WAY_W  = DEF_WAY_W,
   parameter int BEAT_W = DEF_BEAT_W
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   lk_valid,
   output logic                   lk_ready,
   input  logic [SET_W-1:0]       lk_set,
   output logic                   rsp_valid,
   output logic [SET_W-1:0]       rsp_set,
   input  logic                   fill_req,
   output logic                   fill_ack,
   input  logic [SET_W-1:0]       fill_set,
   input  logic [WAY_W-1:0]       fill_way,
   input  logic                   fill_bvalid,
   output logic                   fill_bready,
   input  logic [BEAT_W-1:0]      fill_bdata,
   output logic                   fill_done,
   input  logic                   st_valid,
   output logic                   st_ready,
   input  logic [SET_W-1:0]       st_set,
   input  logic [WAY_W-1:0]       st_way,
   input  logic [1:0]             st_qtr,
   input  logic [BEAT_W-1:0]      st_data,
   output logic [SET_W-1:0]       bk_rd_addr,
   output logic [SET_W+WAY_W-1:0] bk_wr_addr,
   output logic [BEAT_W-1:0]      bk_wr_data,
   output logic [NUM_QTR-1:0]     bk_wr_en
`ifdef DATA_CTRL_PERF_EN
   ,
   output logic [31:0]            perf_lk_stall,
   output logic [31:0]            perf_wr_hold
`endif
);

   localparam logic [NUM_QTR-1:0] ONE_HOT0 = {{(NUM_QTR-1){1'b0}}, 1'b1};

   state_t           state;
   logic [1:0]       beat_cnt;
   logic [SET_W-1:0] fill_set_q;
   logic [WAY_W-1:0] fill_way_q;
   logic             s1_valid;
   logic [SET_W-1:0] s1_set;
   logic             in_fill;
   logic             fill_hit_rd;
   logic             st_hit_rd;
   logic             beat_wr;
   logic             st_wr;
   logic             lk_acc;

   // A lookup in stage 1 reads at the end of this cycle, so a same-set write now must wait.
   assign in_fill     = (state == FILL);
   assign fill_hit_rd = s1_valid && (s1_set == fill_set_q);
   assign st_hit_rd   = s1_valid && (s1_set == st_set);

   assign lk_ready    = rst_n && !(in_fill && (lk_set == fill_set_q));
   assign lk_acc      = lk_valid && lk_ready;
   assign bk_rd_addr  = lk_set;

   assign fill_ack    = rst_n && !in_fill && fill_req;
   assign fill_bready = rst_n && in_fill && !fill_hit_rd;
   assign beat_wr     = fill_bready && fill_bvalid;
   assign fill_done   = beat_wr && (beat_cnt == 2'd3);

   assign st_ready    = rst_n && !beat_wr && !st_hit_rd && !(in_fill && (st_set == fill_set_q));
   assign st_wr       = st_valid && st_ready;

   always_comb begin
      bk_wr_en   = '0;
      bk_wr_addr = '0;
      bk_wr_data = '0;
      if (beat_wr) begin
         bk_wr_en   = ONE_HOT0 << beat_cnt;
         bk_wr_addr = {fill_set_q, fill_way_q};
         bk_wr_data = fill_bdata;
      end else if (st_wr) begin
         bk_wr_en   = ONE_HOT0 << st_qtr;
         bk_wr_addr = {st_set, st_way};
         bk_wr_data = st_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         beat_cnt   <= 2'd0;
         fill_set_q <= '0;
         fill_way_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (fill_req) begin
                  state      <= FILL;
                  beat_cnt   <= 2'd0;
                  fill_set_q <= fill_set;
                  fill_way_q <= fill_way;
               end
            end
            FILL: begin
               if (beat_wr) begin
                  beat_cnt <= beat_cnt + 2'd1;
                  if (beat_cnt == 2'd3) state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   data_ctrl_rd_pipe #(.SET_W(SET_W)) u_rd_pipe (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (lk_acc),
      .in_set    (lk_set),
      .s1_valid  (s1_valid),
      .s1_set    (s1_set),
      .rsp_valid (rsp_valid),
      .rsp_set   (rsp_set)
   );

`ifdef DATA_CTRL_PERF_EN
   logic wr_hold;
   assign wr_hold = (in_fill && fill_bvalid && fill_hit_rd) || (st_valid && st_hit_rd);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         perf_lk_stall <= '0;
         perf_wr_hold  <= '0;
      end else begin
         if (lk_valid && !lk_ready) perf_lk_stall <= perf_lk_stall + 32'd1;
         if (wr_hold)               perf_wr_hold  <= perf_wr_hold + 32'd1;
      end
   end
`endif

endmodule
